vram_arbiter: RTL

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_if.sv | 34 +++
 rtl/vram_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/vram_if.sv
// Frame-buffer arbiter bus: display timing, writer handshake, RAM port and pixel stream.
// master = timing/writer/RAM side, slave = the arbiter.
interface vram_if #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 4
) ();
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       H_pos;
  logic [31:0]       V_pos;
  logic              valid_video;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output H_pos, V_pos, valid_video, wr_valid, wr_addr, wr_data, mem_rdata,
    input  wr_ready, mem_addr, mem_wdata, mem_we, pix_data, pix_valid, fifo_count
  );

  modport slave (
    input  H_pos, V_pos, valid_video, wr_valid, wr_addr, wr_data, mem_rdata,
    output wr_ready, mem_addr, mem_wdata, mem_we, pix_data, pix_valid, fifo_count
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch owns the RAM during active video, queued writes drain in blanking.
// Optional macro VRAM_FRAME_SYNC_WR_EN restricts draining to vertical blanking (tear-free updates).
module vram_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input logic   clk,
  input logic   reset_ctr,
  vram_if.slave bus
);
  // Shared frame geometry
  localparam int IMAGE_WIDTH  = 1280;
  localparam int IMAGE_HEIGHT = 720;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W        = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, DISP, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop, drain_ok;
  logic              vld_p0, vld_p1;

  function automatic logic [ADDR_W-1:0] lin_addr(input logic [31:0] h, input logic [31:0] v);
    logic [31:0] lin;
    lin = v * 32'(IMAGE_WIDTH) + h;
    return lin[ADDR_W-1:0];
  endfunction

  assign bus.wr_ready   = (count_q < CNT_W'(FIFO_DEPTH));
  assign bus.fifo_count = count_q;
  assign push           = bus.wr_valid && bus.wr_ready;

`ifdef VRAM_FRAME_SYNC_WR_EN
  assign drain_ok = !bus.valid_video && (bus.V_pos >= 32'(IMAGE_HEIGHT));
`else
  assign drain_ok = !bus.valid_video;
`endif

  // Pop decision uses this cycle's inputs so a rising valid_video always wins the port.
  assign pop = (state_q == DRAIN) && drain_ok && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CNT_W'(1);
    else if (pop && !push)
      count_d = count_q - CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    if (bus.valid_video)
      state_d = DISP;
    else if ((count_d != '0) && drain_ok)
      state_d = DRAIN;
    else
      state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset_ctr) begin
      state_q <= IDLE;
      count_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.wr_addr;
      fifo_data[wr_ptr] <= bus.wr_data;
    end
  end

  // Stage p0: RAM port registers (display read address or drained write)
  always_ff @(posedge clk) begin
    if (reset_ctr) begin
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_we    <= 1'b0;
      vld_p0        <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      vld_p0     <= bus.valid_video;
      if (bus.valid_video) begin
        bus.mem_addr <= lin_addr(bus.H_pos, bus.V_pos);
      end else if (pop) begin
        bus.mem_addr  <= fifo_addr[rd_ptr];
        bus.mem_wdata <= fifo_data[rd_ptr];
        bus.mem_we    <= 1'b1;
      end
    end
  end

  // Stage p1: RAM read data returning; output stage registers it as the pixel
  always_ff @(posedge clk) begin
    if (reset_ctr) begin
      vld_p1        <= 1'b0;
      bus.pix_valid <= 1'b0;
      bus.pix_data  <= '0;
    end else begin
      vld_p1        <= vld_p0;
      bus.pix_valid <= vld_p1;
      if (vld_p1)
        bus.pix_data <= bus.mem_rdata;
    end
  end
endmodule
